// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for a bidirectional serial shift register: accepts a
// shift command via start/busy/done and drives the register's en/direction/d pins.
module shift_seq_ctrl #(
  parameter int MSB = 4,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dir_req,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] nshift,
  input  logic          abort,
  input  logic          ser_in,
  input  logic [MSB-1:0] reg_q,
  output logic          sr_en,
  output logic          sr_dir,
  output logic          sr_d,
  output logic          ser_out,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  localparam logic [CW-1:0] REM_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] REM_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]    state_r;
  logic [1:0]    state_next_s;
  logic          dir_r;
  logic [1:0]    mode_r;
  logic [CW-1:0] rem_r;
  logic          fill_s;

  // Bit that leaves the register in the given direction; also the rotate feedback.
  function automatic logic exit_bit(input logic [MSB-1:0] q, input logic dir);
    return dir ? q[MSB-1] : q[0];
  endfunction

  // Next-state decode; abort in SHIFT takes priority over the last-shift exit.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = (nshift != REM_ZERO) ? SHIFT : DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next_s = IDLE;
        end else if (rem_r == REM_ONE) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Command fields are captured on acceptance so later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_r  <= 1'b0;
      mode_r <= 2'b00;
      rem_r  <= REM_ZERO;
    end else if ((state_r == IDLE) && start && (nshift != REM_ZERO)) begin
      dir_r  <= dir_req;
      mode_r <= mode;
      rem_r  <= nshift;
    end else if (state_r == SHIFT) begin
      rem_r  <= rem_r - REM_ONE;
    end else begin
      rem_r  <= rem_r;
    end
  end

  // Fill-bit source selection.
  always_comb begin
    fill_s = 1'b0;
    case (mode_r)
      2'b00:   fill_s = ser_in;
      2'b01:   fill_s = exit_bit(reg_q, dir_r);
      2'b10:   fill_s = 1'b0;
      2'b11:   fill_s = 1'b1;
      default: fill_s = 1'b0;
    endcase
  end

  // Strobes decode straight from the state register, so reset clears them at once.
  assign sr_en   = (state_r == SHIFT);
  assign busy    = (state_r == SHIFT);
  assign done    = (state_r == DONE);
  assign sr_dir  = sr_en & dir_r;
  assign sr_d    = sr_en & fill_s;
  assign ser_out = sr_en & exit_bit(reg_q, dir_r);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: a behavioural 4-bit shift register closes
// the loop; table vectors plus hand sequences for abort, restart and reset.
module tb_shift_seq_ctrl;

  localparam int MSB = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, dir_req, abort, ser_in;
  logic [1:0]    mode;
  logic [CW-1:0] nshift;
  logic [MSB-1:0] reg_q;
  logic          sr_en, sr_dir, sr_d, ser_out, busy, done;
  logic          load;
  logic [MSB-1:0] load_val;

  int n_total = 0;
  int n_pass  = 0;

  shift_seq_ctrl #(.MSB(MSB), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .dir_req(dir_req), .mode(mode),
    .nshift(nshift), .abort(abort), .ser_in(ser_in), .reg_q(reg_q),
    .sr_en(sr_en), .sr_dir(sr_dir), .sr_d(sr_d), .ser_out(ser_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // The external shift register being sequenced, with a bench preload port.
  always @(posedge clk) begin
    if (rst)        reg_q <= 4'b0000;
    else if (load)  reg_q <= load_val;
    else if (sr_en) reg_q <= sr_dir ? {reg_q[MSB-2:0], sr_d} : {sr_d, reg_q[MSB-1:1]};
  end

  typedef struct {
    logic       dir;
    logic [1:0] md;
    logic [3:0] n;
    logic       sin;
    logic [3:0] pre;
    logic [3:0] exp_q;
    int         exp_en;
    int         exp_done_cyc;
    logic [15:0] exp_seq;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic preload(input logic [3:0] v);
    @(negedge clk);
    load = 1'b1; load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, output int en_cnt, output int done_cnt,
                         output int done_cyc, output int bad, output logic [15:0] seq);
    en_cnt = 0; done_cnt = 0; done_cyc = -1; bad = 0; seq = 16'h0000;
    preload(v.pre);
    dir_req = v.dir; mode = v.md; nshift = v.n; ser_in = v.sin; start = 1'b1;
    for (int c = 1; c <= int'(v.n) + 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sr_en) begin
        en_cnt++;
        seq = {seq[14:0], ser_out};
        if (sr_dir !== v.dir) bad++;
      end
      if (busy !== sr_en) bad++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
    end
  endtask

  initial begin
    int en_cnt, done_cnt, done_cyc, bad;
    logic [15:0] seq;

    vecs[0] = '{1'b1, 2'b01, 4'd4,  1'b0, 4'b1011, 4'b1011, 4,  5,  16'h000B};
    vecs[1] = '{1'b0, 2'b00, 4'd3,  1'b1, 4'b0000, 4'b1110, 3,  4,  16'h0000};
    vecs[2] = '{1'b1, 2'b01, 4'd0,  1'b0, 4'b0110, 4'b0110, 0,  1,  16'h0000};
    vecs[3] = '{1'b1, 2'b11, 4'd6,  1'b0, 4'b0000, 4'b1111, 6,  7,  16'h0003};
    vecs[4] = '{1'b0, 2'b01, 4'd5,  1'b0, 4'b0001, 4'b1000, 5,  6,  16'h0011};
    vecs[5] = '{1'b1, 2'b10, 4'd2,  1'b1, 4'b1111, 4'b1100, 2,  3,  16'h0003};
    vecs[6] = '{1'b0, 2'b11, 4'd15, 1'b0, 4'b0000, 4'b1111, 15, 16, 16'h07FF};
    vecs[7] = '{1'b1, 2'b00, 4'd1,  1'b0, 4'b1000, 4'b0000, 1,  2,  16'h0001};

    rst = 1'b1; start = 1'b0; dir_req = 1'b0; mode = 2'b00; nshift = 4'd0;
    abort = 1'b0; ser_in = 1'b1; load = 1'b0; load_val = 4'b0000;

    // Outputs quiet in reset and after release.
    @(negedge clk);
    check("reset_outputs", {26'd0, sr_en, sr_dir, sr_d, ser_out, busy, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_after_reset", {26'd0, sr_en, sr_dir, sr_d, ser_out, busy, done}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], en_cnt, done_cnt, done_cyc, bad, seq);
      check($sformatf("v%0d_final_q", i), {28'd0, reg_q}, {28'd0, vecs[i].exp_q});
      check($sformatf("v%0d_en_cycles", i), en_cnt, vecs[i].exp_en);
      check($sformatf("v%0d_done_count", i), done_cnt, 1);
      check($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done_cyc);
      check($sformatf("v%0d_ser_out_seq", i), {16'd0, seq}, {16'd0, vecs[i].exp_seq});
      check($sformatf("v%0d_busy_dir", i), bad, 0);
    end

    // Start re-pulsed during SHIFT and DONE with different fields: ignored.
    preload(4'b0000);
    dir_req = 1'b1; mode = 2'b11; nshift = 4'd6; start = 1'b1;
    en_cnt = 0; done_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (sr_en) en_cnt++;
      if (done) done_cnt++;
      if (c == 2 || c == 7) begin
        start = 1'b1; dir_req = 1'b0; mode = 2'b10; nshift = 4'd1;
      end else begin
        start = 1'b0;
      end
    end
    check("restart_en_cycles", en_cnt, 6);
    check("restart_done_count", done_cnt, 1);
    check("restart_final_q", {28'd0, reg_q}, 32'h0000000F);

    // Abort on the 3rd shift, then a new command one cycle later.
    preload(4'b1111);
    dir_req = 1'b1; mode = 2'b10; nshift = 4'd5; start = 1'b1;
    en_cnt = 0; done_cnt = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sr_en) en_cnt++;
      if (done) done_cnt++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_en_cycles", en_cnt, 3);
    check("abort_no_done", done_cnt, 0);
    check("abort_idle_next", {29'd0, sr_en, busy, done}, 32'd0);
    check("abort_reg_q", {28'd0, reg_q}, 32'h00000008);
    dir_req = 1'b1; mode = 2'b11; nshift = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("after_abort_accepted", {31'd0, sr_en}, 32'd1);
    @(negedge clk);
    check("after_abort_done", {31'd0, done}, 32'd1);
    check("after_abort_reg_q", {28'd0, reg_q}, 32'h00000001);

    // Abort coinciding with the last shift suppresses done.
    preload(4'b0000);
    dir_req = 1'b1; mode = 2'b11; nshift = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_last_en", {31'd0, sr_en}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_last_no_done", {30'd0, sr_en, done}, 32'd0);
    @(negedge clk);
    check("abort_last_still_no_done", {31'd0, done}, 32'd0);
    check("abort_last_reg_q", {28'd0, reg_q}, 32'h00000003);

    // No combinational path from start, then async reset mid-SHIFT.
    preload(4'b0000);
    dir_req = 1'b1; mode = 2'b11; nshift = 4'd6; start = 1'b1;
    #1;
    check("start_no_comb_path", {31'd0, sr_en}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_shifting", {30'd0, sr_en, busy}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("async_reset_clears", {29'd0, sr_en, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if ({sr_en, sr_dir, sr_d, ser_out, busy, done} !== 6'b000000) bad++;
    end
    check("idle_after_async_reset", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
